motor_pwm: RTL and testbench



---
 rtl/kovan_mot_pkg.sv | 13 +
 rtl/motor_pwm_channel.sv | 132 +++++++++++++
 rtl/motor_pwm.sv | 78 +++++++
 tb/tb_motor_pwm.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kovan_mot_pkg.sv
// Shared drive-code encodings and counter width for the motor PWM block.
package kovan_mot_pkg;

  localparam int MOT_CNT_W = 16;

  typedef logic [1:0] mot_code_t;

  localparam mot_code_t MOT_COAST = 2'b00;
  localparam mot_code_t MOT_FWD   = 2'b01;
  localparam mot_code_t MOT_REV   = 2'b10;
  localparam mot_code_t MOT_BRAKE = 2'b11;

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: shadow registers, compare, optional dead-time FSM, output mapping.
// MOT_DEADTIME_EN adds the DRIVE/DEAD FSM; without it reversals apply directly at the load.
//
// state    | meaning
// ST_DRIVE | outputs follow the shadow drive code
// ST_DEAD  | outputs forced to coast while the dead counter runs down
module motor_pwm_channel
  import kovan_mot_pkg::*;
#(
  parameter int DEAD_CYCLES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [MOT_CNT_W-1:0] i_cnt_nxt,
  input  logic [MOT_CNT_W-1:0] i_duty,
  input  mot_code_t            i_code,
  input  logic                 i_brake,
  input  logic                 i_coast,
  output logic                 o_ina,
  output logic                 o_inb,
  output logic                 o_pwm
);

  logic [MOT_CNT_W-1:0] r_duty_sh;
  mot_code_t            r_code_sh;
  logic                 r_ina, r_inb, r_pwm;

  logic [MOT_CNT_W-1:0] w_duty_nxt;
  mot_code_t            w_code_nxt;
  logic                 w_raw;
  logic                 w_dead_act;
  logic                 w_ina, w_inb, w_pwm;

  // Outputs are registered from next-state values so new shadows show with period_start.
  assign w_duty_nxt = i_load ? i_duty : r_duty_sh;
  assign w_code_nxt = i_load ? i_code : r_code_sh;
  assign w_raw      = (i_cnt_nxt < w_duty_nxt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty_sh <= '0;
      r_code_sh <= MOT_COAST;
    end else if (i_load) begin
      r_duty_sh <= i_duty;
      r_code_sh <= i_code;
    end
  end

`ifdef MOT_DEADTIME_EN
  typedef enum logic {ST_DRIVE, ST_DEAD} state_t;

  localparam logic [MOT_CNT_W-1:0] DEAD_LAST = MOT_CNT_W'(DEAD_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [MOT_CNT_W-1:0] r_dead, w_dead_nxt;
  logic                 w_qualify;

  assign w_qualify = i_load && ((i_code == MOT_FWD) || (i_code == MOT_REV))
                     && (i_code != r_code_sh);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_DRIVE;
      r_dead  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dead  <= w_dead_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dead_nxt  = r_dead;
    if (w_qualify) begin
      w_state_nxt = ST_DEAD;
      w_dead_nxt  = DEAD_LAST;
    end else if (i_load) begin
      w_state_nxt = ST_DRIVE;
      w_dead_nxt  = '0;
    end else if (r_state == ST_DEAD) begin
      if (r_dead == '0) w_state_nxt = ST_DRIVE;
      else              w_dead_nxt  = r_dead - 1'b1;
    end
  end

  assign w_dead_act = (w_state_nxt == ST_DEAD);
`else
  assign w_dead_act = 1'b0;
`endif

  // Allstop sits after the FSM; coast wins over brake.
  always_comb begin
    w_ina = 1'b0;
    w_inb = 1'b0;
    w_pwm = 1'b0;
    if (!w_dead_act) begin
      case (w_code_nxt)
        MOT_FWD:   begin w_ina = 1'b1; w_pwm = w_raw; end
        MOT_REV:   begin w_inb = 1'b1; w_pwm = w_raw; end
        MOT_BRAKE: begin w_ina = 1'b1; w_inb = 1'b1; w_pwm = 1'b1; end
        default:   ;
      endcase
    end
    if (i_coast) begin
      w_ina = 1'b0;
      w_inb = 1'b0;
      w_pwm = 1'b0;
    end else if (i_brake) begin
      w_ina = 1'b1;
      w_inb = 1'b1;
      w_pwm = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ina <= 1'b0;
      r_inb <= 1'b0;
      r_pwm <= 1'b0;
    end else begin
      r_ina <= w_ina;
      r_inb <= w_inb;
      r_pwm <= w_pwm;
    end
  end

  assign o_ina = r_ina;
  assign o_inb = r_inb;
  assign o_pwm = r_pwm;

endmodule

// File: rtl/motor_pwm.sv
// Four-channel H-bridge PWM generator: shared prescaler, period counter and period strobe.
// Define MOT_DEADTIME_EN to insert dead-time on direction changes in each channel.
module motor_pwm
  import kovan_mot_pkg::*;
#(
  parameter int                   CLK_DIV     = 4,
  parameter logic [MOT_CNT_W-1:0] TOP         = 16'd999,
  parameter int                   DEAD_CYCLES = 8
) (
  input  logic                 SYS_CLK,
  input  logic                 SYS_RST_N,
  input  logic [MOT_CNT_W-1:0] mot_duty0,
  input  logic [MOT_CNT_W-1:0] mot_duty1,
  input  logic [MOT_CNT_W-1:0] mot_duty2,
  input  logic [MOT_CNT_W-1:0] mot_duty3,
  input  logic [7:0]           mot_drive_code,
  input  logic [4:0]           mot_allstop,
  output logic [3:0]           mot_ina,
  output logic [3:0]           mot_inb,
  output logic [3:0]           mot_pwm,
  output logic                 period_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]        r_presc;
  logic [MOT_CNT_W-1:0] r_cnt;
  logic                 r_period_start;

  logic                 w_tick;
  logic                 w_load;
  logic [MOT_CNT_W-1:0] w_cnt_nxt;
  logic [MOT_CNT_W-1:0] w_duty [4];

  // With CLK_DIV=1 the prescaler is pinned at 0 and tick is constant.
  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_load    = w_tick && (r_cnt == TOP);
  assign w_cnt_nxt = w_load ? '0 : (w_tick ? r_cnt + 1'b1 : r_cnt);

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_tick ? '0 : r_presc + 1'b1;
      r_cnt          <= w_cnt_nxt;
      r_period_start <= w_load;
    end
  end

  assign period_start = r_period_start;

  assign w_duty[0] = mot_duty0;
  assign w_duty[1] = mot_duty1;
  assign w_duty[2] = mot_duty2;
  assign w_duty[3] = mot_duty3;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    motor_pwm_channel #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch (
      .i_clk     (SYS_CLK),
      .i_rst_n   (SYS_RST_N),
      .i_load    (w_load),
      .i_cnt_nxt (w_cnt_nxt),
      .i_duty    (w_duty[k]),
      .i_code    (mot_drive_code[2*k+1:2*k]),
      .i_brake   (mot_allstop[k]),
      .i_coast   (mot_allstop[4]),
      .o_ina     (mot_ina[k]),
      .o_inb     (mot_inb[k]),
      .o_pwm     (mot_pwm[k])
    );
  end

endmodule

// File: tb/tb_motor_pwm.sv
// Scoreboard bench for motor_pwm: expectations queued with stimulus, compared after measurement.
module tb_motor_pwm;

  localparam int          CLK_DIV = 4;
  localparam logic [15:0] TOP     = 16'd999;
  localparam int          DEAD    = 8;
  localparam int          PER     = CLK_DIV * (int'(TOP) + 1);
`ifdef MOT_DEADTIME_EN
  localparam int DT = DEAD;
`else
  localparam int DT = 0;
`endif

  logic        SYS_CLK;
  logic        SYS_RST_N;
  logic [15:0] mot_duty0, mot_duty1, mot_duty2, mot_duty3;
  logic [7:0]  mot_drive_code;
  logic [4:0]  mot_allstop;
  logic [3:0]  mot_ina, mot_inb, mot_pwm;
  logic        period_start;

  motor_pwm #(
    .CLK_DIV(CLK_DIV),
    .TOP(TOP),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .SYS_CLK(SYS_CLK),
    .SYS_RST_N(SYS_RST_N),
    .mot_duty0(mot_duty0),
    .mot_duty1(mot_duty1),
    .mot_duty2(mot_duty2),
    .mot_duty3(mot_duty3),
    .mot_drive_code(mot_drive_code),
    .mot_allstop(mot_allstop),
    .mot_ina(mot_ina),
    .mot_inb(mot_inb),
    .mot_pwm(mot_pwm),
    .period_start(period_start)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_q[$];
  string name_q[$];
  int    got_q[$];

  int         m_hi[4];
  int         m_len;
  int         m_first_inb1;
  int         m_ina1_hi;
  logic [3:0] m_ina_mid, m_inb_mid;

  task automatic push_exp(input string nm, input int v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  // Entered on the negedge where period_start is high; returns on the next one.
  task automatic measure_period();
    m_len = 0;
    m_first_inb1 = -1;
    m_ina1_hi = 0;
    for (int k = 0; k < 4; k++) m_hi[k] = 0;
    do begin
      for (int k = 0; k < 4; k++) if (mot_pwm[k]) m_hi[k]++;
      if (mot_ina[1]) m_ina1_hi++;
      if (mot_inb[1] && m_first_inb1 < 0) m_first_inb1 = m_len;
      if (m_len == PER / 2) begin
        m_ina_mid = mot_ina;
        m_inb_mid = mot_inb;
      end
      m_len++;
      @(negedge SYS_CLK);
    end while (!period_start && m_len < PER + 1000);
  endtask

  task automatic wait_ps(output int n, output int dirty);
    n = 0;
    dirty = 0;
    do begin
      @(negedge SYS_CLK);
      n++;
      if (!period_start && ((mot_ina | mot_inb | mot_pwm) != 4'd0)) dirty++;
    end while (!period_start && n < PER + 1000);
  endtask

  task automatic test_reset();
    int n, dirty, g, e;
    string nm;
    SYS_RST_N      = 1'b0;
    mot_duty0      = 16'd250;
    mot_duty1      = 16'd999;
    mot_duty2      = 16'd0;
    mot_duty3      = 16'd1000;
    mot_drive_code = 8'h65;
    mot_allstop    = 5'd0;
    repeat (3) @(negedge SYS_CLK);
    push_exp("rst_ina", 0);
    push_exp("rst_inb", 0);
    push_exp("rst_pwm", 0);
    push_exp("rst_period_start", 0);
    got_q.push_back(int'(mot_ina));
    got_q.push_back(int'(mot_inb));
    got_q.push_back(int'(mot_pwm));
    got_q.push_back(int'(period_start));
    SYS_RST_N = 1'b1;
    push_exp("first_period_start_latency", PER);
    push_exp("coast_before_first_load", 0);
    wait_ps(n, dirty);
    got_q.push_back(n);
    got_q.push_back(dirty);
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
    end
  endtask

  task automatic test_basic_duty();
    int g, e;
    string nm;
    push_exp("A_period_len", PER);
    push_exp("A_pwm0_duty250", 1000 - DT);
    push_exp("A_pwm1_duty999", 3996 - DT);
    push_exp("A_pwm2_duty0", 0);
    push_exp("A_pwm3_duty1000", PER - DT);
    push_exp("A_ina_mid", 4'b1011);
    push_exp("A_inb_mid", 4'b0100);
    measure_period();
    got_q.push_back(m_len);
    for (int k = 0; k < 4; k++) got_q.push_back(m_hi[k]);
    got_q.push_back(int'(m_ina_mid));
    got_q.push_back(int'(m_inb_mid));
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
    end
  endtask

  task automatic test_mid_period_write();
    int g, e;
    string nm;
    push_exp("B_period_len", PER);
    push_exp("B_pwm0_unchanged", 1000);
    push_exp("B_pwm1_low4", 3996);
    push_exp("B_pwm2_never", 0);
    push_exp("B_pwm3_full", PER);
    push_exp("B_ina1_fwd", PER);
    fork
      measure_period();
      begin
        repeat (PER / 2) @(negedge SYS_CLK);
        mot_duty0      = 16'd750;
        mot_duty3      = 16'hFFFF;
        mot_drive_code = 8'h69;
      end
    join
    got_q.push_back(m_len);
    for (int k = 0; k < 4; k++) got_q.push_back(m_hi[k]);
    got_q.push_back(m_ina1_hi);
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
    end
  endtask

  task automatic test_reversal();
    int g, e;
    string nm;
    push_exp("C_period_len", PER);
    push_exp("C_pwm0_duty750", 3000);
    push_exp("C_pwm1_rev", 3996 - DT);
    push_exp("C_pwm2_never", 0);
    push_exp("C_pwm3_ffff", PER);
    push_exp("C_inb1_first_cycle", DT);
    push_exp("C_ina1_high_cycles", 0);
    push_exp("C_ina_mid", 4'b1001);
    push_exp("C_inb_mid", 4'b0110);
    measure_period();
    got_q.push_back(m_len);
    for (int k = 0; k < 4; k++) got_q.push_back(m_hi[k]);
    got_q.push_back(m_first_inb1);
    got_q.push_back(m_ina1_hi);
    got_q.push_back(int'(m_ina_mid));
    got_q.push_back(int'(m_inb_mid));
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
    end
  endtask

  task automatic test_allstop();
    int g, e;
    string nm;
    repeat (100) @(negedge SYS_CLK);
    mot_allstop = 5'b00100;
    push_exp("as_not_early_pwm", 4'b1011);
    #1;
    got_q.push_back(int'(mot_pwm));
    push_exp("as_brake2_ina", 4'b1101);
    push_exp("as_brake2_inb", 4'b0110);
    push_exp("as_brake2_pwm", 4'b1111);
    @(negedge SYS_CLK);
    got_q.push_back(int'(mot_ina));
    got_q.push_back(int'(mot_inb));
    got_q.push_back(int'(mot_pwm));
    mot_allstop = 5'b10100;
    push_exp("as_coast_ina", 0);
    push_exp("as_coast_inb", 0);
    push_exp("as_coast_pwm", 0);
    @(negedge SYS_CLK);
    got_q.push_back(int'(mot_ina));
    got_q.push_back(int'(mot_inb));
    got_q.push_back(int'(mot_pwm));
    mot_allstop = 5'b00000;
    push_exp("as_release_ina", 4'b1001);
    push_exp("as_release_inb", 4'b0110);
    push_exp("as_release_pwm", 4'b1011);
    @(negedge SYS_CLK);
    got_q.push_back(int'(mot_ina));
    got_q.push_back(int'(mot_inb));
    got_q.push_back(int'(mot_pwm));
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, dirty, g, e;
    string nm;
    @(negedge SYS_CLK);
    #2 SYS_RST_N = 1'b0;
    push_exp("rm_ina", 0);
    push_exp("rm_inb", 0);
    push_exp("rm_pwm", 0);
    push_exp("rm_period_start", 0);
    #1;
    got_q.push_back(int'(mot_ina));
    got_q.push_back(int'(mot_inb));
    got_q.push_back(int'(mot_pwm));
    got_q.push_back(int'(period_start));
    repeat (3) @(negedge SYS_CLK);
    SYS_RST_N = 1'b1;
    push_exp("rm_first_period_start_latency", PER);
    push_exp("rm_coast_until_load", 0);
    wait_ps(n, dirty);
    got_q.push_back(n);
    got_q.push_back(dirty);
    push_exp("E_period_len", PER);
    push_exp("E_pwm0", 3000 - DT);
    push_exp("E_pwm1", 3996 - DT);
    push_exp("E_pwm2", 0);
    push_exp("E_pwm3", PER - DT);
    push_exp("E_inb1_first_cycle", DT);
    push_exp("E_ina_mid", 4'b1001);
    push_exp("E_inb_mid", 4'b0110);
    measure_period();
    got_q.push_back(m_len);
    for (int k = 0; k < 4; k++) got_q.push_back(m_hi[k]);
    got_q.push_back(m_first_inb1);
    got_q.push_back(int'(m_ina_mid));
    got_q.push_back(int'(m_inb_mid));
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, g, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no summary by time %0t expected finish earlier", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    test_reset();
    test_basic_duty();
    test_mid_period_write();
    test_reversal();
    test_allstop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
